interval_timer_ctrl: RTL and testbench
======================================

INTERVAL_TIMER_CTRL -- requirements
Module: interval_timer_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the counter and period width in bits.
REQ-002 Parameter PRESCALE, default 4, SHALL set clocks per count tick; it exists only when TIMER_PRESCALE_EN is defined.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be a one-cycle request that latches period and begins a run.
REQ-006 stop  input  1  SHALL be a one-cycle request that aborts a run and returns to IDLE.
REQ-007 period  input  WIDTH  SHALL be the run length in ticks, sampled only when start is accepted.
REQ-008 auto_reload  input  1  SHALL select periodic (1) or one-shot (0) mode, sampled with period.
REQ-009 irq_clr  input  1  SHALL clear the sticky irq flag.
REQ-010 count  output  WIDTH  SHALL be the current tick count.
REQ-011 busy  output  1  SHALL be high while in RUN.
REQ-012 expired  output  1  SHALL pulse for exactly one cycle at each period end.
REQ-013 irq  output  1  SHALL be a sticky expiry flag.

Function
REQ-014 FSM SHALL have states IDLE and RUN; IDLE->RUN on start; RUN->IDLE on stop or on one-shot expiry; RUN->RUN on periodic expiry.
REQ-015 Accepting start SHALL clear count to 0, latch period and auto_reload, and assert busy in the next cycle.
REQ-016 In RUN, count SHALL increment by 1 on every tick; in IDLE, count SHALL hold its value.
REQ-017 When a tick occurs with count == latched_period-1, count SHALL return to 0 and expired SHALL be high in the next cycle.
REQ-018 Latched period 0 SHALL mean 2^WIDTH ticks: expiry fires when count wraps from all-ones to 0.
REQ-019 Latched period 1 SHALL give an expired pulse on every tick.
REQ-020 stop and start in the same cycle SHALL resolve as stop: the FSM goes to IDLE, count clears to 0, and no expiry occurs.
REQ-021 start during RUN SHALL restart the run: count clears, period and mode are re-latched, and any coincident expiry is suppressed.
REQ-022 stop during RUN SHALL clear count to 0 and drop busy in the next cycle; stop in IDLE SHALL have no effect.
REQ-023 irq SHALL set on each expired pulse and clear on irq_clr; when both occur in the same cycle, set SHALL win.
REQ-024 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-025 Asserting reset SHALL immediately force IDLE, count=0, busy=0, expired=0, irq=0, and clear the latched period, mode and prescaler.
REQ-026 Reset asserted mid-run SHALL abort the run with no expired pulse; after release, the block SHALL wait for a new start.

Configuration
REQ-027 With TIMER_PRESCALE_EN defined, a tick SHALL occur once every PRESCALE clocks in RUN; the prescaler SHALL clear on start, stop and expiry.
REQ-028 Without TIMER_PRESCALE_EN, a tick SHALL occur on every clock in RUN, and no prescaler logic SHALL exist.

Structure
REQ-029 Package timer_ctrl_pkg SHALL hold the FSM state enum (IDLE, RUN) and the default WIDTH constant.
REQ-030 Sub-module tick_counter SHALL hold the WIDTH-bit counter, with inputs clk, reset, clear and inc and output count; the FSM and irq logic SHALL stay in the top level.

Verification
REQ-031 Scenario: period=5, one-shot, start (no prescale) -> count 0..4, expired pulses once at the 5th tick, busy falls the same cycle, irq=1.
REQ-032 Scenario: period=3, auto_reload=1, run 9 ticks -> exactly 3 expired pulses 3 ticks apart, busy stays 1.
REQ-033 Scenario: period=0, WIDTH=8 -> first expired pulse after 256 ticks; period=1 -> expired pulse on every tick.
REQ-034 Scenario: start and stop in the same cycle while RUN at count=2 -> IDLE, count=0, no expired pulse.
REQ-035 Scenario: reset asserted at count=3 mid-run -> all outputs 0 asynchronously; expired and irq irq_clr coincident with expired -> irq remains 1.
REQ-036 Scenario: TIMER_PRESCALE_EN, PRESCALE=4, period=2 -> expired pulse 8 clocks after start is accepted.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the interval timer controller.
//   timer_state_t : FSM state encoding (IDLE, RUN)
//   DEFAULT_WIDTH : default counter / period width in bits
package timer_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// Bus bundle between a timer user (master) and interval_timer_ctrl (slave).
//   start, stop, period, auto_reload, irq_clr : requests/config from the master
//   count, busy, expired, irq, dbg_state       : registered status from the slave
// Handshake: start/stop/irq_clr are single-cycle strobes with no ready; the
// timer accepts them unconditionally on the next rising clk edge.
interface interval_timer_ctrl_if
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic             stop;
  logic [WIDTH-1:0] period;
  logic             auto_reload;
  logic             irq_clr;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             expired;
  logic             irq;
  timer_state_t     dbg_state;

  modport master (
    output start, stop, period, auto_reload, irq_clr,
    input  count, busy, expired, irq, dbg_state
  );

  modport slave (
    input  start, stop, period, auto_reload, irq_clr,
    output count, busy, expired, irq, dbg_state
  );

endinterface

// File: rtl/interval_timer_ctrl_tick_counter.sv
// tick_counter: WIDTH-bit up counter with synchronous clear.
//   clk   : clock
//   reset : asynchronous active-low reset
//   clear : force count to 0 (has priority over inc)
//   inc   : add 1 (wraps naturally at 2^WIDTH)
//   count : current value
module tick_counter
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl: one-shot / periodic interval timer.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : interval_timer_ctrl_if.slave (start/stop/period/auto_reload/irq_clr in;
//           count/busy/expired/irq/dbg_state out, all registered)
// Optional feature: define TIMER_PRESCALE_EN to add parameter PRESCALE, making a
// count tick occur once every PRESCALE clocks instead of every clock.
module interval_timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
`ifdef TIMER_PRESCALE_EN
  , parameter int PRESCALE = 4
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  interval_timer_ctrl_if.slave bus
);

  timer_state_t     state_q, state_d;
  logic [WIDTH-1:0] period_q;
  logic             reload_q;
  logic [WIDTH-1:0] count;
  logic             expired_q;
  logic             irq_q;
  logic             run;
  logic             tick;
  logic             advance;
  logic             wrap;
  logic             clear;
  logic             restart;

  assign run     = (state_q == RUN);
  // stop beats start; a start with stop is not a restart.
  assign restart = bus.start && !bus.stop;
  // Any start or stop in RUN pre-empts the tick, so no expiry can coincide.
  assign advance = run && tick && !bus.stop && !bus.start;
  // period - 1 in WIDTH bits makes period 0 expire at all-ones (2^WIDTH ticks).
  assign wrap    = advance && (count == (period_q - WIDTH'(1)));
  // start always clears (even when stop wins); stop clears only in RUN.
  assign clear   = bus.start || (bus.stop && run) || wrap;

`ifdef TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre_q;

  assign tick = run && (pre_q == PW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
    end else if (bus.start || bus.stop || wrap || tick) begin
      pre_q <= '0;
    end else if (run) begin
      pre_q <= pre_q + PW'(1);
    end
  end
`else
  assign tick = run;
`endif

  tick_counter #(.WIDTH(WIDTH)) u_tick_counter (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (advance),
    .count (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (restart) state_d = RUN;
      RUN: begin
        if (bus.stop)                 state_d = IDLE;
        else if (bus.start)           state_d = RUN;
        else if (wrap && !reload_q)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_q  <= '0;
      reload_q  <= 1'b0;
      expired_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (restart) begin
        period_q <= bus.period;
        reload_q <= bus.auto_reload;
      end
      expired_q <= wrap;
      // irq sets on the same edge that raises expired; set beats irq_clr.
      if (wrap)             irq_q <= 1'b1;
      else if (bus.irq_clr) irq_q <= 1'b0;
    end
  end

  assign bus.count     = count;
  assign bus.busy      = run;
  assign bus.expired   = expired_q;
  assign bus.irq       = irq_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Testbench for interval_timer_ctrl (WIDTH = 8).
module tb_interval_timer_ctrl;
  import timer_ctrl_pkg::*;

  localparam int W = 8;
`ifdef TIMER_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  interval_timer_ctrl_if #(.WIDTH(W)) bus ();

  interval_timer_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W+2:0] exp_q[$];

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Tracks elapsed ticks of the current period as a plain integer.
  bit m_run, m_reload, m_irq, m_exp;
  int m_cnt, m_plen, m_pre;

  function automatic void model_reset();
    m_run = 0; m_reload = 0; m_irq = 0; m_exp = 0;
    m_cnt = 0; m_plen = 0; m_pre = 0;
  endfunction

  function automatic void model_step(input bit s, input bit p, input int per,
                                     input bit ar, input bit clr);
    m_exp = 0;
    if (m_run) begin
      if (p) begin
        m_run = 0; m_cnt = 0; m_pre = 0;
      end else if (s) begin
        m_plen = (per == 0) ? (1 << W) : per;
        m_reload = ar; m_cnt = 0; m_pre = 0;
      end else begin
        m_pre++;
        if (m_pre == PS) begin
          m_pre = 0;
          m_cnt++;
          if (m_cnt == m_plen) begin
            m_cnt = 0;
            m_exp = 1;
            if (!m_reload) m_run = 0;
          end
        end
      end
    end else if (s) begin
      m_cnt = 0; m_pre = 0;
      if (!p) begin
        m_run = 1;
        m_plen = (per == 0) ? (1 << W) : per;
        m_reload = ar;
      end
    end
    if (m_exp) m_irq = 1;
    else if (clr) m_irq = 0;
  endfunction

  // ---------------- driver ----------------
  // Called #1 after a rising edge; returns #1 after the next rising edge.
  task automatic step(input bit s, input bit p, input logic [W-1:0] per,
                      input bit ar, input bit clr);
    logic [W+2:0] got, exp;
    bus.start = s; bus.stop = p; bus.period = per;
    bus.auto_reload = ar; bus.irq_clr = clr;
    model_step(s, p, int'(per), ar, clr);
    exp_q.push_back({W'(m_cnt), m_run, m_exp, m_irq});
    @(posedge clk);
    #1;
    got = {bus.count, bus.busy, bus.expired, bus.irq};
    exp = exp_q.pop_front();
    chk("model{count,busy,expired,irq}", int'(got), int'(exp));
    chk("dbg_state", int'(bus.dbg_state == RUN), int'(m_run));
    bus.start = 0; bus.stop = 0; bus.irq_clr = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, bus.period, bus.auto_reload, 0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit s, p; logic [W-1:0] per; bit ar, clr;
    int c; bit b, e, i;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit s, p, input int per, input bit ar, clr,
                              input int c, input bit b, e, i);
    vec_t v;
    v.s = s; v.p = p; v.per = W'(per); v.ar = ar; v.clr = clr;
    v.c = c; v.b = b; v.e = e; v.i = i;
    tbl.push_back(v);
  endfunction

  initial begin
    int n, hits, last;
    // one-shot, period 5
    add(1,0,5,0,0, 0,1,0,0);
    add(0,0,5,0,0, 1,1,0,0);
    add(0,0,5,0,0, 2,1,0,0);
    add(0,0,5,0,0, 3,1,0,0);
    add(0,0,5,0,0, 4,1,0,0);
    add(0,0,5,0,0, 0,0,1,1);
    add(0,0,5,0,0, 0,0,0,1);
    add(0,0,5,0,1, 0,0,0,0);
    // start+stop while running at count 2
    add(1,0,7,0,0, 0,1,0,0);
    add(0,0,7,0,0, 1,1,0,0);
    add(0,0,7,0,0, 2,1,0,0);
    add(1,1,7,0,0, 0,0,0,0);
    add(0,0,7,0,0, 0,0,0,0);
    add(0,1,7,0,0, 0,0,0,0);
    // periodic period 3, then stop mid-run
    add(1,0,3,1,0, 0,1,0,0);
    add(0,0,3,1,0, 1,1,0,0);
    add(0,0,3,1,0, 2,1,0,0);
    add(0,0,3,1,0, 0,1,1,1);
    add(0,0,3,1,0, 1,1,0,1);
    add(0,1,3,1,0, 0,0,0,1);
    // restart coincident with expiry suppresses it
    add(1,0,2,1,0, 0,1,0,1);
    add(0,0,2,1,0, 1,1,0,1);
    add(1,0,6,0,0, 0,1,0,1);
    add(0,0,6,0,0, 1,1,0,1);
    add(0,1,6,0,0, 0,0,0,1);
    add(0,0,6,0,1, 0,0,0,0);
    // irq_clr on the expiry edge: set wins
    add(1,0,2,0,0, 0,1,0,0);
    add(0,0,2,0,0, 1,1,0,0);
    add(0,0,2,0,1, 0,0,1,1);
    add(0,0,2,0,1, 0,0,0,0);
    // period 1: expiry every tick
    add(1,0,1,1,0, 0,1,0,0);
    add(0,0,1,1,0, 0,1,1,1);
    add(0,0,1,1,0, 0,1,1,1);
    add(0,1,1,1,0, 0,0,0,1);
    add(0,0,1,1,1, 0,0,0,0);

    // reset
    bus.start = 0; bus.stop = 0; bus.period = '0;
    bus.auto_reload = 0; bus.irq_clr = 0;
    reset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_expired", int'(bus.expired), 0);
    chk("rst_irq", int'(bus.irq), 0);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;

`ifndef TIMER_PRESCALE_EN
    foreach (tbl[k]) begin
      step(tbl[k].s, tbl[k].p, tbl[k].per, tbl[k].ar, tbl[k].clr);
      chk($sformatf("vec%0d_count", k), int'(bus.count), tbl[k].c);
      chk($sformatf("vec%0d_busy", k), int'(bus.busy), int'(tbl[k].b));
      chk($sformatf("vec%0d_expired", k), int'(bus.expired), int'(tbl[k].e));
      chk($sformatf("vec%0d_irq", k), int'(bus.irq), int'(tbl[k].i));
    end

    // periodic period 3 over 9 ticks: 3 pulses, 3 ticks apart
    step(1, 0, 3, 1, 0);
    hits = 0; last = 0;
    for (int i = 1; i <= 9; i++) begin
      idle(1);
      if (bus.expired) begin
        chk("p3_spacing", i - last, 3);
        last = i;
        hits++;
      end
    end
    chk("p3_pulses", hits, 3);
    chk("p3_busy", int'(bus.busy), 1);
    step(0, 1, 3, 1, 1);
`else
    // prescale 4, period 2: pulse 8 clocks after start
    step(1, 0, 2, 0, 0);
    n = 0;
    while (n < 20) begin
      idle(1);
      n++;
      if (bus.expired) break;
    end
    chk("prescale_latency", n, 8 * PS / 4);
`endif

    // period 0: 2^W ticks to the first pulse
    step(1, 0, 0, 0, 0);
    n = 0;
    while (n < 300 * PS) begin
      idle(1);
      n++;
      if (bus.expired) break;
    end
    chk("p0_latency", n, (1 << W) * PS);

    // asynchronous reset mid-run at count 3
    step(1, 0, 9, 0, 0);
    idle(3 * PS);
    chk("pre_rst_count", int'(bus.count), 3);
    #2;
    reset = 0;
    #1;
    chk("arst_count", int'(bus.count), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_expired", int'(bus.expired), 0);
    chk("arst_irq", int'(bus.irq), 0);
    model_reset();
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    idle(12);
    chk("post_rst_busy", int'(bus.busy), 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           W'($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 6)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
    end
    step(0, 1, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
